// File: rtl/jtag_dma_cmd_issuer_if.sv
// Command/response, DMA-master handshake and shared-buffer port bundle for jtag_dma_cmd_issuer.
// master = the issuer side, slave = the JTAG front end / DMA master / buffer side.
interface jtag_dma_cmd_issuer_if;
  logic        cmd_valid;
  logic [71:0] cmd_data;
  logic        cmd_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_status;
  logic        ipcore_dataReady;
  logic        ipcore_readReady;
  logic [3:0]  ipcore_byteEnable;
  logic [31:0] ipcore_address_to_read;
  logic        ipcore_switch_ready;
  logic [8:0]  bufferAddress;
  logic [31:0] dataIn;
  logic        writeEnable;
  logic [31:0] dataOut;

  modport master (
    input  cmd_valid, cmd_data, rsp_ready, ipcore_switch_ready, dataOut,
    output cmd_ready, rsp_valid, rsp_data, rsp_status,
           ipcore_dataReady, ipcore_readReady, ipcore_byteEnable, ipcore_address_to_read,
           bufferAddress, dataIn, writeEnable
  );

  modport slave (
    output cmd_valid, cmd_data, rsp_ready, ipcore_switch_ready, dataOut,
    input  cmd_ready, rsp_valid, rsp_data, rsp_status,
           ipcore_dataReady, ipcore_readReady, ipcore_byteEnable, ipcore_address_to_read,
           bufferAddress, dataIn, writeEnable
  );
endinterface

// File: rtl/jtag_dma_cmd_issuer.sv
// Issues one JTAG command at a time to the DMA bus master through the shared buffer, one response each.
// Optional: define JTAG_CMD_ALIGN_CHECK_EN to reject word-misaligned addresses with status 2'b11.
module jtag_dma_cmd_issuer #(
  parameter logic [8:0] BUFFER_ADDR    = 9'h000,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  jtag_dma_cmd_issuer_if.master bus,
  output logic [2:0]            s_issuer_cur_state
);

  localparam logic [3:0] OP_WRITE = 4'h1;
  localparam logic [3:0] OP_READ  = 4'h2;

  localparam logic [1:0] ST_OK       = 2'b00;
  localparam logic [1:0] ST_TIMEOUT  = 2'b01;
  localparam logic [1:0] ST_ILLEGAL  = 2'b10;
  localparam logic [1:0] ST_MISALIGN = 2'b11;

  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WRITE_BUF = 3'd1,
    ISSUE     = 3'd2,
    WAIT_BUSY = 3'd3,
    WAIT_DONE = 3'd4,
    READ_BUF  = 3'd5,
    CAPTURE   = 3'd6,
    RESPOND   = 3'd7
  } state_t;

  state_t state, state_nxt;

  logic [3:0]       cmd_op;
  logic             cmd_legal;
  logic             cmd_misaligned;
  logic             accept;
  logic             timeout_hit;
  logic             switch_ready;

  logic [3:0]       byte_en_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic             is_read_q;
  logic [31:0]      rsp_data_q;
  logic [1:0]       rsp_status_q;
  logic [CNT_W-1:0] wait_cnt;

  assign cmd_op       = bus.cmd_data[71:68];
  assign cmd_legal    = (cmd_op == OP_WRITE) || (cmd_op == OP_READ);
  assign switch_ready = bus.ipcore_switch_ready;
  assign accept       = bus.cmd_valid & bus.cmd_ready;
  assign timeout_hit  = (wait_cnt == CNT_LAST);

`ifdef JTAG_CMD_ALIGN_CHECK_EN
  assign cmd_misaligned = (bus.cmd_data[33:32] != 2'b00);
`else
  assign cmd_misaligned = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!cmd_legal || cmd_misaligned) state_nxt = RESPOND;
          else if (cmd_op == OP_WRITE)      state_nxt = WRITE_BUF;
          else                              state_nxt = ISSUE;
        end
      end
      WRITE_BUF: state_nxt = ISSUE;
      ISSUE:     state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (timeout_hit)        state_nxt = RESPOND;
        else if (!switch_ready) state_nxt = WAIT_DONE;
      end
      // A completion seen on the last counted cycle takes priority over the timeout.
      WAIT_DONE: begin
        if (switch_ready)     state_nxt = is_read_q ? READ_BUF : RESPOND;
        else if (timeout_hit) state_nxt = RESPOND;
      end
      READ_BUF:  state_nxt = CAPTURE;
      CAPTURE:   state_nxt = RESPOND;
      RESPOND:   if (bus.rsp_ready) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.cmd_ready        = reset & (state == IDLE) & switch_ready;
    bus.rsp_valid        = (state == RESPOND);
    bus.ipcore_dataReady = (state == ISSUE) & ~is_read_q;
    bus.ipcore_readReady = (state == ISSUE) &  is_read_q;
    bus.writeEnable      = (state == WRITE_BUF);
    bus.dataIn           = (state == WRITE_BUF) ? wdata_q : 32'h0;
    bus.bufferAddress    = BUFFER_ADDR;
  end

  // Command fields are held from accept until the next accept so the DMA master sees stable values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      byte_en_q    <= 4'h0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      is_read_q    <= 1'b0;
      rsp_data_q   <= 32'h0;
      rsp_status_q <= ST_OK;
      wait_cnt     <= '0;
    end else begin
      if (accept) begin
        byte_en_q  <= bus.cmd_data[67:64];
        addr_q     <= bus.cmd_data[63:32];
        wdata_q    <= bus.cmd_data[31:0];
        is_read_q  <= (cmd_op == OP_READ);
        rsp_data_q <= 32'h0;
        if (!cmd_legal)          rsp_status_q <= ST_ILLEGAL;
        else if (cmd_misaligned) rsp_status_q <= ST_MISALIGN;
        else                     rsp_status_q <= ST_OK;
      end

      if (state == ISSUE)
        wait_cnt <= '0;
      else if (state == WAIT_BUSY || state == WAIT_DONE)
        wait_cnt <= wait_cnt + CNT_W'(1);

      if ((state == WAIT_BUSY && timeout_hit) ||
          (state == WAIT_DONE && !switch_ready && timeout_hit))
        rsp_status_q <= ST_TIMEOUT;

      if (state == CAPTURE)
        rsp_data_q <= bus.dataOut;
    end
  end

  assign bus.rsp_data               = rsp_data_q;
  assign bus.rsp_status             = rsp_status_q;
  assign bus.ipcore_byteEnable      = byte_en_q;
  assign bus.ipcore_address_to_read = addr_q;
  assign s_issuer_cur_state         = state;

endmodule

// File: tb/tb_jtag_dma_cmd_issuer.sv
// Self-checking bench for jtag_dma_cmd_issuer: directed and randomized commands against a
// transaction-level reference model, with a small DMA-master and shared-buffer model.
module tb_jtag_dma_cmd_issuer;

  localparam int         TMO  = 16;
  localparam logic [8:0] BADR = 9'h000;

  logic       clock;
  logic       reset;
  logic [2:0] cur_state;

  jtag_dma_cmd_issuer_if ifc ();

  jtag_dma_cmd_issuer #(
    .BUFFER_ADDR   (BADR),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .bus               (ifc.master),
    .s_issuer_cur_state(cur_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // DMA master model: after a start pulse it stays busy for dma_busy cycles, then (for a read)
  // deposits dma_rdval in the exchange word. With dma_hang it never reacts at all.
  int          dma_busy  = 1;
  bit          dma_hang  = 1'b0;
  logic [31:0] dma_rdval = 32'h0;
  int          busy_cnt;
  bit          rd_pending;
  logic [31:0] mem [0:511];

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      ifc.ipcore_switch_ready <= 1'b1;
      busy_cnt                <= 0;
      rd_pending              <= 1'b0;
    end else begin
      if (ifc.writeEnable) mem[ifc.bufferAddress] <= ifc.dataIn;
      if ((ifc.ipcore_dataReady || ifc.ipcore_readReady) && !dma_hang) begin
        ifc.ipcore_switch_ready <= 1'b0;
        busy_cnt                <= dma_busy;
        rd_pending              <= ifc.ipcore_readReady;
      end else if (busy_cnt > 0) begin
        busy_cnt <= busy_cnt - 1;
        if (busy_cnt == 1) begin
          ifc.ipcore_switch_ready <= 1'b1;
          if (rd_pending) mem[BADR] <= dma_rdval;
        end
      end
    end
  end

  always @(posedge clock) ifc.dataOut <= mem[ifc.bufferAddress];

  // Event monitors, sampled on the inactive edge.
  int          dr_cnt = 0, rr_cnt = 0, wr_cnt = 0, stab_err = 0, rsp_seen = 0;
  logic [31:0] wr_val = 32'h0;
  logic [8:0]  wr_addr = 9'h0;
  bit          in_flight = 1'b0;
  logic [31:0] exp_a = 32'h0;
  logic [3:0]  exp_be = 4'h0;

  always @(negedge clock) begin
    if (ifc.ipcore_dataReady) dr_cnt++;
    if (ifc.ipcore_readReady) rr_cnt++;
    if (ifc.rsp_valid)        rsp_seen++;
    if (ifc.writeEnable) begin
      wr_cnt++;
      wr_val  = ifc.dataIn;
      wr_addr = ifc.bufferAddress;
    end
    if (in_flight && (ifc.ipcore_address_to_read !== exp_a || ifc.ipcore_byteEnable !== exp_be))
      stab_err++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: what one command should produce, from the command fields and the DMA behaviour.
  // The issuer tolerates TMO wait cycles; this DMA model signals completion in wait cycle busy+1.
  function automatic void ref_rsp(input logic [3:0] op, input logic [31:0] addr, input int busy,
                                  input bit hang, input logic [31:0] rdval,
                                  output logic [1:0] st, output logic [31:0] d,
                                  output int ndr, output int nrr, output int nwr);
    bit align_chk;
`ifdef JTAG_CMD_ALIGN_CHECK_EN
    align_chk = 1'b1;
`else
    align_chk = 1'b0;
`endif
    st = 2'b00; d = 32'h0; ndr = 0; nrr = 0; nwr = 0;
    if (op != 4'h1 && op != 4'h2) st = 2'b10;
    else if (align_chk && addr[1:0] != 2'b00) st = 2'b11;
    else begin
      ndr = (op == 4'h1) ? 1 : 0;
      nrr = (op == 4'h2) ? 1 : 0;
      nwr = ndr;
      if (hang || (busy + 1 > TMO)) st = 2'b01;
      else if (op == 4'h2) d = rdval;
    end
  endfunction

  task automatic do_cmd(input string tag, input logic [3:0] op, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wd, input int busy,
                        input bit hang, input logic [31:0] rdval, input int hold);
    logic [1:0]  es;
    logic [31:0] ed;
    int          edr, err, ewr, n, dr0, rr0, wr0, se0;
    bit          got;
    logic [31:0] hd;
    logic [1:0]  hs;
    dma_busy  = busy;
    dma_hang  = hang;
    dma_rdval = rdval;
    @(negedge clock);
    dr0 = dr_cnt; rr0 = rr_cnt; wr0 = wr_cnt; se0 = stab_err;
    ifc.cmd_valid = 1'b1;
    ifc.cmd_data  = {op, be, addr, wd};
    got = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (ifc.cmd_ready) begin got = 1'b1; break; end
      @(negedge clock);
    end
    check({tag, " accept"}, {31'b0, got}, 32'd1);
    exp_a  = addr;
    exp_be = be;
    @(negedge clock);
    ifc.cmd_valid = 1'b0;
    in_flight     = 1'b1;
    n   = 0;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (ifc.rsp_valid) begin got = 1'b1; break; end
      n++;
      @(negedge clock);
    end
    check({tag, " rsp_valid"}, {31'b0, got}, 32'd1);
    ref_rsp(op, addr, busy, hang, rdval, es, ed, edr, err, ewr);
    check({tag, " status"}, {30'b0, ifc.rsp_status}, {30'b0, es});
    check({tag, " data"}, ifc.rsp_data, ed);
    check({tag, " dataReady pulses"}, 32'(dr_cnt - dr0), 32'(edr));
    check({tag, " readReady pulses"}, 32'(rr_cnt - rr0), 32'(err));
    check({tag, " buffer writes"}, 32'(wr_cnt - wr0), 32'(ewr));
    if (ewr == 1) begin
      check({tag, " buffer wdata"}, wr_val, wd);
      check({tag, " buffer addr"}, {23'b0, wr_addr}, {23'b0, BADR});
    end
    if (es == 2'b10 || es == 2'b11) check({tag, " latency"}, 32'(n), 32'd0);
    check({tag, " addr/be stable"}, 32'(stab_err - se0), 32'd0);
    hd = ifc.rsp_data;
    hs = ifc.rsp_status;
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      check({tag, " held valid"}, {31'b0, ifc.rsp_valid}, 32'd1);
      check({tag, " held data"}, ifc.rsp_data, hd);
      check({tag, " held status"}, {30'b0, ifc.rsp_status}, {30'b0, hs});
      check({tag, " held cmd_ready"}, {31'b0, ifc.cmd_ready}, 32'd0);
    end
    ifc.rsp_ready = 1'b1;
    @(negedge clock);
    ifc.rsp_ready = 1'b0;
    in_flight     = 1'b0;
    check({tag, " rsp_valid drop"}, {31'b0, ifc.rsp_valid}, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          r, rs0;
    logic [3:0]  op;
    bit          got;
    reset         = 1'b0;
    ifc.cmd_valid = 1'b0;
    ifc.cmd_data  = 72'h0;
    ifc.rsp_ready = 1'b0;
    repeat (3) @(negedge clock);
    check("rst cmd_ready", {31'b0, ifc.cmd_ready}, 32'd0);
    check("rst rsp_valid", {31'b0, ifc.rsp_valid}, 32'd0);
    check("rst rsp_data", ifc.rsp_data, 32'h0);
    check("rst rsp_status", {30'b0, ifc.rsp_status}, 32'd0);
    check("rst pulses", {30'b0, ifc.ipcore_dataReady, ifc.ipcore_readReady}, 32'd0);
    check("rst byteEnable", {28'b0, ifc.ipcore_byteEnable}, 32'd0);
    check("rst address", ifc.ipcore_address_to_read, 32'h0);
    check("rst bufferAddress", {23'b0, ifc.bufferAddress}, {23'b0, BADR});
    check("rst dataIn", ifc.dataIn, 32'h0);
    check("rst writeEnable", {31'b0, ifc.writeEnable}, 32'd0);
    check("rst state", {29'b0, cur_state}, 32'd0);
    reset = 1'b1;
    @(negedge clock);
    check("idle cmd_ready", {31'b0, ifc.cmd_ready}, 32'd1);

    do_cmd("write", 4'h1, 4'hF, 32'h4000_0010, 32'hCAFE_F00D, 3, 1'b0, 32'h0, 0);
    check("write buffer word", mem[BADR], 32'hCAFE_F00D);
    do_cmd("read", 4'h2, 4'hF, 32'h4000_0020, 32'h0, 4, 1'b0, 32'h1234_5678, 0);
    do_cmd("illegal op", 4'h7, 4'hF, 32'h4000_0030, 32'h1111_2222, 2, 1'b0, 32'h0, 0);
    do_cmd("hang timeout", 4'h1, 4'h3, 32'h4000_0040, 32'h5555_AAAA, 1, 1'b1, 32'h0, 0);
    do_cmd("read last cycle", 4'h2, 4'hC, 32'h4000_0044, 32'h0, TMO - 1, 1'b0, 32'hA5A5_0F0F, 0);
    do_cmd("write busy timeout", 4'h1, 4'hF, 32'h4000_0048, 32'h0BAD_BEEF, TMO, 1'b0, 32'h0, 0);
    do_cmd("read hold", 4'h2, 4'h1, 32'h4000_0050, 32'h0, 2, 1'b0, 32'hDEAD_0001, 5);
    do_cmd("misaligned", 4'h1, 4'hF, 32'h4000_0002, 32'h7777_8888, 2, 1'b0, 32'h0, 0);
    do_cmd("be zero", 4'h1, 4'h0, 32'h4000_0060, 32'h0000_00FF, 1, 1'b0, 32'h0, 1);

    for (int k = 0; k < 24; k++) begin
      r = $urandom_range(0, 9);
      if (r < 4)      op = 4'h1;
      else if (r < 8) op = 4'h2;
      else            op = 4'($urandom);
      do_cmd($sformatf("rand%0d", k), op, 4'($urandom), $urandom, $urandom,
             $urandom_range(1, 18), ($urandom_range(0, 7) == 0), $urandom,
             $urandom_range(0, 3));
    end

    // Reset in the middle of a long DMA wait must abandon the command without a response.
    dma_busy = 40;
    dma_hang = 1'b0;
    @(negedge clock);
    ifc.cmd_valid = 1'b1;
    ifc.cmd_data  = {4'h1, 4'hF, 32'h4000_0070, 32'h0102_0304};
    got = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (ifc.cmd_ready) begin got = 1'b1; break; end
      @(negedge clock);
    end
    check("midrst accept", {31'b0, got}, 32'd1);
    @(negedge clock);
    ifc.cmd_valid = 1'b0;
    repeat (4) @(negedge clock);
    reset = 1'b0;
    #1;
    check("midrst state", {29'b0, cur_state}, 32'd0);
    check("midrst address", ifc.ipcore_address_to_read, 32'h0);
    check("midrst rsp_valid", {31'b0, ifc.rsp_valid}, 32'd0);
    check("midrst cmd_ready", {31'b0, ifc.cmd_ready}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    rs0 = rsp_seen;
    repeat (40) @(negedge clock);
    check("midrst no response", 32'(rsp_seen - rs0), 32'd0);
    check("midrst idle ready", {31'b0, ifc.cmd_ready}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
